vedic_mult_pipe: RTL

VEDIC_MULT_PIPE -- requirements
Module: vedic_mult_pipe

---
 rtl/vedic_mult_pipe.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: 3-stage signed/unsigned Vedic multiplier with
// valid/ready handshakes, in-order results and a sideband tag.

module ks_add #(
    parameter int N = 8
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] s
);
    // Prefix tree covers the low N-1 bits; the MSB only needs its carry-in.
    localparam int M = N - 1;
    localparam int L = (M > 1) ? $clog2(M) : 0;

    logic [M-1:0] p0;
    logic [M-1:0] gg;
    logic [M-1:0] tt;
    logic [M-1:0] gn;
    logic [M-1:0] tn;
    logic [M:0]   cc;

    always_comb begin
        gg = x[M-1:0] & y[M-1:0];
        tt = x[M-1:0] ^ y[M-1:0];
        gn = gg;
        tn = tt;
        for (int l = 0; l < L; l++) begin
            for (int i = (1 << l); i < M; i++) begin
                gn[i] = gg[i] | (tt[i] & gg[i-(1<<l)]);
                tn[i] = tt[i] & tt[i-(1<<l)];
            end
            gg = gn;
            tt = tn;
        end
    end

    assign p0 = x[M-1:0] ^ y[M-1:0];
    assign cc = {gg | (tt & {M{cin}}), cin};
    assign s  = {x[N-1] ^ y[N-1] ^ cc[M], p0 ^ cc[M-1:0]};
endmodule

module vedic_comb #(
    parameter int H = 2
) (
    input  logic [2*H-1:0] ll,
    input  logic [2*H-1:0] lh,
    input  logic [2*H-1:0] hl,
    input  logic [2*H-1:0] hh,
    output logic [4*H-1:0] p
);
    logic [2*H:0]   mid;
    logic [3*H-1:0] hi;

    ks_add #(.N(2*H+1)) u_mid (
        .x   ({1'b0, lh}),
        .y   ({1'b0, hl}),
        .cin (1'b0),
        .s   (mid)
    );

    // Low H bits of ll pass straight through; the cross terms land above them.
    ks_add #(.N(3*H)) u_hi (
        .x   ({hh, ll[2*H-1:H]}),
        .y   ({{(H-1){1'b0}}, mid}),
        .cin (1'b0),
        .s   (hi)
    );

    assign p = {hi, ll[H-1:0]};
endmodule

module vedic_mul #(
    parameter int N = 4
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);
    if (N == 2) begin : g_cell
        logic c0;
        logic c1;
        logic k;
        logic t;
        assign c0 = a[1] & b[0];
        assign c1 = a[0] & b[1];
        assign k  = c0 & c1;
        assign t  = a[1] & b[1];
        assign p  = {t & k, t ^ k, c0 ^ c1, a[0] & b[0]};
    end else begin : g_rec
        localparam int H = N / 2;
        logic [N-1:0] ll;
        logic [N-1:0] lh;
        logic [N-1:0] hl;
        logic [N-1:0] hh;

        vedic_mul #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
        vedic_mul #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(lh));
        vedic_mul #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(hl));
        vedic_mul #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(hh));

        vedic_comb #(.H(H)) u_comb (
            .ll (ll),
            .lh (lh),
            .hl (hl),
            .hh (hh),
            .p  (p)
        );
    end
endmodule

module vedic_mult_pipe #(
    parameter int W     = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   p,
    output logic [TAG_W-1:0] out_tag
);
    localparam int H = W / 2;

    typedef struct packed {
        logic             v;
        logic             sgn;
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     a;
        logic [W-1:0]     b;
    } s1_t;

    typedef struct packed {
        logic             v;
        logic             neg;
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     ll;
        logic [W-1:0]     lh;
        logic [W-1:0]     hl;
        logic [W-1:0]     hh;
    } s2_t;

    s1_t s1;
    s2_t s2;

    logic           stall;
    logic [W-1:0]   ma;
    logic [W-1:0]   mb;
    logic [W-1:0]   ll;
    logic [W-1:0]   lh;
    logic [W-1:0]   hl;
    logic [W-1:0]   hh;
    logic [2*W-1:0] mag;
    logic [2*W-1:0] res;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // -2^(W-1) negates to itself, which reads correctly as an unsigned magnitude.
    assign ma = (s1.sgn & s1.a[W-1]) ? -s1.a : s1.a;
    assign mb = (s1.sgn & s1.b[W-1]) ? -s1.b : s1.b;

    vedic_mul #(.N(H)) u_ll (.a(ma[H-1:0]), .b(mb[H-1:0]), .p(ll));
    vedic_mul #(.N(H)) u_lh (.a(ma[H-1:0]), .b(mb[W-1:H]), .p(lh));
    vedic_mul #(.N(H)) u_hl (.a(ma[W-1:H]), .b(mb[H-1:0]), .p(hl));
    vedic_mul #(.N(H)) u_hh (.a(ma[W-1:H]), .b(mb[W-1:H]), .p(hh));

    vedic_comb #(.H(H)) u_comb (
        .ll (s2.ll),
        .lh (s2.lh),
        .hl (s2.hl),
        .hh (s2.hh),
        .p  (mag)
    );

    ks_add #(.N(2*W)) u_neg (
        .x   (mag ^ {(2*W){s2.neg}}),
        .y   ('0),
        .cin (s2.neg),
        .s   (res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            out_valid <= 1'b0;
            p         <= '0;
            out_tag   <= '0;
        end else if (!stall) begin
            s1.v      <= in_valid;
            s1.sgn    <= in_signed;
            s1.tag    <= in_tag;
            s1.a      <= a;
            s1.b      <= b;
            s2.v      <= s1.v;
            s2.neg    <= s1.sgn & (s1.a[W-1] ^ s1.b[W-1]);
            s2.tag    <= s1.tag;
            s2.ll     <= ll;
            s2.lh     <= lh;
            s2.hl     <= hl;
            s2.hh     <= hh;
            out_valid <= s2.v;
            p         <= res;
            out_tag   <= s2.tag;
        end
    end
endmodule
